uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among several byte producers. It runs on the system clock, accepts bytes through per-requester valid/ready handshakes, and drives the transmitter's new-data strobe and data byte. It holds the strobe until the transmitter reports completion, and recovers with an error flag if completion never arrives.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 2_000_000: clk cycles allowed from strobe assertion to completion before abort. Must be ≥ 2.
- Derived IDW = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte-available flags.
- req_data  in  8*NUM_REQ  flat bytes; requester i occupies bits [8i+7:8i].
- req_enable  in  NUM_REQ  arbitration mask; a 0 bit excludes that requester.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- tx_newd  out  1  new-data strobe to the transmitter; level, held until completion.
- tx_data  out  8  byte presented to the transmitter; stable while tx_newd=1.
- tx_done  in  1  transmitter completion flag; high for one or more clk cycles.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  IDW  index of the requester currently or most recently granted.
- timeout_err  out  1  one-cycle pulse on abort.
- sent_count  out  16  count of successfully completed bytes; wraps at 0xFFFF→0.

## Operation
- States: IDLE, SEND, DRAIN.
- **IDLE:**
  - Candidates are the requesters with req_valid[i] & req_enable[i].
  - Search starts at last_grant+1 and wraps modulo NUM_REQ. The first candidate found wins.
  - On a win, in the same clk edge: register req_data of the winner into tx_data, pulse req_ready[winner], set grant_id=winner, set last_grant=winner, set tx_newd=1, clear the timeout counter, and go to SEND.
  - With no candidate, remain in IDLE.
- **SEND:**
  - The timeout counter increments each cycle.
  - The block samples tx_done through one register, prev_done.
  - A rising edge (tx_done & ~prev_done) means completion: tx_newd→0, sent_count+1, go to DRAIN.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: tx_newd→0, pulse timeout_err, go to DRAIN. sent_count is not incremented.
  - If the rising edge and the timeout coincide, completion wins and no error is raised.
- **DRAIN:**
  - Wait until tx_done=0, then go to IDLE.
  - This guarantees the transmitter has consumed its done phase before the next strobe, so one completion is never counted twice.
- prev_done is updated every cycle in all states.
- req_valid and req_data are sampled only in IDLE. Changes in other states have no effect.
- A requester whose enable bit is cleared mid-transfer still completes; the mask affects only future arbitration.

## Timing
- Reset values:
  - tx_newd=0, tx_data=0x00, req_ready=0, busy=0, grant_id=0, timeout_err=0, sent_count=0.
  - State is IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), prev_done=0.
- Request to strobe: the req_ready pulse and the tx_newd rise are in the same cycle, one clk after the IDLE cycle that sees a valid request.
- Completion: tx_newd falls one clk after the cycle in which tx_done is first seen high.
- Minimum IDLE→IDLE turnaround is 3 clk cycles, with tx_done as short as one cycle. After DRAIN exits there is one IDLE cycle before the next grant.
- Reset mid-operation:
  - tx_newd drops on the next edge.
  - A byte already accepted is discarded and not retried.
  - sent_count is cleared.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- **Single requester:** after reset, req_valid=4'b0001, req_data[7:0]=0xA5, req_enable=4'hF.
  - req_ready[0] pulses once; tx_newd=1 with tx_data=0xA5.
  - After tx_done is driven high for 3 cycles: tx_newd=0 one cycle later, sent_count=1, busy=0 after tx_done falls.
- **Round-robin:** all four valid with bytes 0x10/0x11/0x12/0x13, held high, tx_done pulsed per byte.
  - Grant order is 0,1,2,3,0.
  - tx_data sequence is 0x10,0x11,0x12,0x13,0x10.
- **Mask:** req_enable=4'b1010 with all requesters valid.
  - Only requesters 1 and 3 are granted, alternating; req_ready[0] and req_ready[2] never assert.
- **Timeout:** TIMEOUT_CYCLES=16, one byte granted, tx_done held low.
  - timeout_err pulses exactly once, 16 cycles after tx_newd rose.
  - tx_newd=0, sent_count unchanged, and the next request is granted normally.
- **Coincidence and reset:**
  - tx_done rises on the final timeout cycle: sent_count increments and timeout_err stays 0.
  - rst asserted while in SEND: the next cycle shows all reset values and state IDLE.
- **Wrap:** force 65536 completions, or preload via a bench hook: sent_count returns to 0x0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Holds tx_newd until a tx_done rising edge, or aborts with timeout_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_enable,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_newd,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_err,
  output logic [15:0]          sent_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t               state, state_n;
  logic [IDW-1:0]       last_grant, last_grant_n, grant_id_n, winner;
  logic [CW-1:0]        tmo_cnt, tmo_cnt_n;
  logic                 prev_done, done_rise, found;
  logic [NUM_REQ-1:0]   cand, req_ready_n;
  logic                 tx_newd_n, timeout_err_n, busy_n;
  logic [7:0]           tx_data_n;
  logic [15:0]          sent_count_n;

  assign cand      = req_valid & req_enable;
  assign done_rise = tx_done & ~prev_done;

  // Scan from the requester after the last winner so every candidate gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && cand[(int'(last_grant) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    grant_id_n    = grant_id;
    tmo_cnt_n     = tmo_cnt;
    tx_newd_n     = tx_newd;
    tx_data_n     = tx_data;
    req_ready_n   = '0;
    timeout_err_n = 1'b0;
    sent_count_n  = sent_count;
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = SEND;
          tx_data_n    = req_data[int'(winner)*8 +: 8];
          req_ready_n  = NUM_REQ'(1) << winner;
          grant_id_n   = winner;
          last_grant_n = winner;
          tx_newd_n    = 1'b1;
          tmo_cnt_n    = '0;
        end
      end
      SEND: begin
        tmo_cnt_n = tmo_cnt + CW'(1);
        // A completion on the final timeout cycle takes precedence over the abort.
        if (done_rise) begin
          tx_newd_n    = 1'b0;
          sent_count_n = sent_count + 16'd1;
          state_n      = DRAIN;
        end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          tx_newd_n     = 1'b0;
          timeout_err_n = 1'b1;
          state_n       = DRAIN;
        end
      end
      DRAIN: begin
        if (!tx_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(NUM_REQ - 1);
      grant_id    <= '0;
      tmo_cnt     <= '0;
      prev_done   <= 1'b0;
      tx_newd     <= 1'b0;
      tx_data     <= 8'h00;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      sent_count  <= 16'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      grant_id    <= grant_id_n;
      tmo_cnt     <= tmo_cnt_n;
      prev_done   <= tx_done;
      tx_newd     <= tx_newd_n;
      tx_data     <= tx_data_n;
      req_ready   <= req_ready_n;
      timeout_err <= timeout_err_n;
      sent_count  <= sent_count_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: handshake, round-robin, masking,
// timeout, completion/timeout coincidence, reset in SEND and count wrap.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_enable;
  logic [3:0]  req_ready;
  logic        tx_newd;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [15:0] sent_count;

  int testCount = 0;
  int failCount = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_enable(req_enable), .req_ready(req_ready), .tx_newd(tx_newd),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] en, input logic d);
    req_valid  = v;
    req_enable = en;
    tx_done    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_newd"},  32'(tx_newd),     32'd0);
    checkOutput({tag, "_data"},  32'(tx_data),     32'h00);
    checkOutput({tag, "_ready"}, 32'(req_ready),   32'd0);
    checkOutput({tag, "_busy"},  32'(busy),        32'd0);
    checkOutput({tag, "_gid"},   32'(grant_id),    32'd0);
    checkOutput({tag, "_terr"},  32'(timeout_err), 32'd0);
    checkOutput({tag, "_cnt"},   32'(sent_count),  32'd0);
  endtask

  // tx_done high for n cycles then low one cycle; leaves the DUT back in IDLE.
  task automatic pulseDone(input int n);
    tx_done = 1'b1;
    repeat (n) step();
    tx_done = 1'b0;
    step();
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_data = 32'h0;
    applyStimulus(4'b0000, 4'hF, 1'b0);
    step();
    step();
    checkReset("reset");
    rst = 1'b0;

    // Single requester with a 3-cycle done
    req_data = 32'h000000A5;
    applyStimulus(4'b0001, 4'hF, 1'b0);
    step();
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    checkOutput("single_newd",  32'(tx_newd),   32'd1);
    checkOutput("single_data",  32'(tx_data),   32'hA5);
    checkOutput("single_busy",  32'(busy),      32'd1);
    req_valid = 4'b0000;
    step();
    checkOutput("single_ready_pulse", 32'(req_ready), 32'h0);
    tx_done = 1'b1;
    step();
    checkOutput("single_newd_fall", 32'(tx_newd),    32'd0);
    checkOutput("single_cnt",       32'(sent_count), 32'd1);
    step();
    step();
    checkOutput("single_drain_busy", 32'(busy), 32'd1);
    tx_done = 1'b0;
    step();
    checkOutput("single_idle_busy", 32'(busy), 32'd0);

    // Round-robin from a fresh reset: 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data = 32'h13121110;
    applyStimulus(4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(4'b0001 << order[i]));
      checkOutput($sformatf("rr%0d_gid", i),   32'(grant_id),  32'(order[i]));
      checkOutput($sformatf("rr%0d_data", i),  32'(tx_data),   32'(8'h10 + order[i]));
      pulseDone(1);
    end
    checkOutput("rr_cnt", 32'(sent_count), 32'd5);

    // Mask 1010: only 1 and 3, alternating
    applyStimulus(4'hF, 4'b1010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("mask%0d_ready", i), 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
      pulseDone(1);
    end
    checkOutput("mask_cnt", 32'(sent_count), 32'd9);

    // Timeout: tx_done never arrives
    applyStimulus(4'b0001, 4'hF, 1'b0);
    step();
    checkOutput("tmo_grant_newd", 32'(tx_newd), 32'd1);
    repeat (15) step();
    checkOutput("tmo_early_terr", 32'(timeout_err), 32'd0);
    checkOutput("tmo_early_newd", 32'(tx_newd),     32'd1);
    step();
    checkOutput("tmo_terr",  32'(timeout_err), 32'd1);
    checkOutput("tmo_newd",  32'(tx_newd),     32'd0);
    checkOutput("tmo_cnt",   32'(sent_count),  32'd9);
    step();
    checkOutput("tmo_terr_pulse", 32'(timeout_err), 32'd0);
    step();
    checkOutput("tmo_regrant_ready", 32'(req_ready), 32'h1);
    checkOutput("tmo_regrant_newd",  32'(tx_newd),   32'd1);
    req_valid = 4'b0000;
    pulseDone(1);
    checkOutput("tmo_regrant_cnt", 32'(sent_count), 32'd10);

    // Completion rising on the last timeout cycle
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    repeat (15) step();
    tx_done = 1'b1;
    step();
    checkOutput("coinc_newd", 32'(tx_newd),     32'd0);
    checkOutput("coinc_terr", 32'(timeout_err), 32'd0);
    checkOutput("coinc_cnt",  32'(sent_count),  32'd11);
    tx_done = 1'b0;
    step();
    checkOutput("coinc_terr_after", 32'(timeout_err), 32'd0);

    // Reset while in SEND
    req_valid = 4'b0001;
    step();
    checkOutput("rstsend_newd", 32'(tx_newd), 32'd1);
    rst = 1'b1;
    step();
    checkReset("rstsend");
    rst = 1'b0;
    req_valid = 4'b0000;
    step();

    // sent_count wrap from a preloaded 0xFFFF
    force dut.sent_count = 16'hFFFF;
    step();
    release dut.sent_count;
    req_valid = 4'b0001;
    step();
    checkOutput("wrap_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    pulseDone(1);
    checkOutput("wrap_cnt", 32'(sent_count), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
